// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter and timing sequencer for one external 16-bit asynchronous
// SRAM. Port A (CPU) and port B (GPU) requests are serialised into strobed
// SRAM cycles: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> IDLE.
// Every pin-level output, ack and rdata is driven straight from a flop.
//
// Parameters:
//   WAIT_STATES   number of ACCESS cycles per transfer (legal 1..15)
//
// Build option:
//   SRAM_ARB_RR_EN  defined   -> round-robin between A and B on a tie
//                   undefined -> fixed priority, A over B
//
// Ports:
//   CLK, RST_N              clock, asynchronous active-low reset
//   a_req/a_we/a_addr/
//   a_wdata/a_be            port A request (held until a_ack)
//   a_ack, a_rdata          port A one-cycle completion pulse, read data
//   b_*                     port B, same meaning as port A
//   busy                    high whenever the FSM is not in IDLE
//   sram_addr, sram_dout,
//   sram_dout_en, sram_din  SRAM address, write data, drive enable, read data
//   CE_N/OE_N/WR_N/UB_N/LB_N active-low SRAM strobes
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        busy,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dout,
  output logic        sram_dout_en,
  input  logic [15:0] sram_din,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WR_N,
  output logic        UB_N,
  output logic        LB_N
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // The ACCESS counter is loaded with WAIT_STATES-1 and the phase ends at 0.
  localparam logic [3:0] ACC_LAST = 4'(WAIT_STATES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        grant_b_q, grant_b_d;   // 1: port B owns the current cycle
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        wr_n_q, wr_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        busy_q, busy_d;

`ifdef SRAM_ARB_RR_EN
  logic        last_grant_q, last_grant_d;  // 1: B won the previous grant
`endif

  logic        pick_b_s;
  logic        win_we_s;
  logic [15:0] win_addr_s;
  logic [15:0] win_wdata_s;
  logic [1:0]  win_be_s;

  // Arbitration: decide which port would win if the FSM accepts now
  always_comb begin
    pick_b_s = 1'b0;
    if (a_req && b_req) begin
`ifdef SRAM_ARB_RR_EN
      pick_b_s = ~last_grant_q;
`else
      pick_b_s = 1'b0;
`endif
    end else if (b_req) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
  end

  assign win_we_s    = pick_b_s ? b_we    : a_we;
  assign win_addr_s  = pick_b_s ? b_addr  : a_addr;
  assign win_wdata_s = pick_b_s ? b_wdata : a_wdata;
  assign win_be_s    = pick_b_s ? b_be    : a_be;

  // Next-state logic; pin values are computed for the coming state so they
  // leave the flops already aligned with it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    grant_b_d = grant_b_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    dout_en_d = dout_en_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    wr_n_d    = wr_n_q;
    ub_n_d    = ub_n_q;
    lb_n_d    = lb_n_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef SRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          state_d   = ST_SETUP;
          we_d      = win_we_s;
          grant_b_d = pick_b_s;
          addr_d    = win_addr_s;
          dout_d    = win_we_s ? win_wdata_s : dout_q;
          dout_en_d = win_we_s;
          ce_n_d    = 1'b0;
          oe_n_d    = win_we_s;      // reads enable the output buffer in SETUP
          wr_n_d    = 1'b1;
          ub_n_d    = ~win_be_s[1];
          lb_n_d    = ~win_be_s[0];
`ifdef SRAM_ARB_RR_EN
          last_grant_d = pick_b_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = ACC_LAST;
        oe_n_d  = we_q;
        wr_n_d  = ~we_q;
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          // Reads capture all 16 bits regardless of byte enables
          if (!we_q && grant_b_q) begin
            b_rdata_d = sram_din;
          end else if (!we_q) begin
            a_rdata_d = sram_din;
          end else begin
            a_rdata_d = a_rdata_q;
          end
          a_ack_d = ~grant_b_q;
          b_ack_d = grant_b_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        // Address and write data were held through this cycle; release now
        state_d   = ST_IDLE;
        dout_en_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        dout_en_d = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and pin registers; RST_N clears everything immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      grant_b_q <= 1'b0;
      addr_q    <= 16'h0000;
      dout_q    <= 16'h0000;
      dout_en_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= 16'h0000;
      b_rdata_q <= 16'h0000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      grant_b_q <= grant_b_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      wr_n_q    <= wr_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin history; resets to B so A wins the first tie
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign busy         = busy_q;
  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign CE_N         = ce_n_q;
  assign OE_N         = oe_n_q;
  assign WR_N         = wr_n_q;
  assign UB_N         = ub_n_q;
  assign LB_N         = lb_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. A cycle-based SRAM model sits on the
// pins of the main instance (WAIT_STATES=1); a second instance with
// WAIT_STATES=3 checks the stretched read timing. Expected transaction results
// are queued when a request is driven and compared when an ack appears.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int WS = 1;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [1:0]  a_be, b_be;
  logic        a_ack, b_ack, busy;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] sram_addr, sram_dout, sram_din;
  logic        sram_dout_en, CE_N, OE_N, WR_N, UB_N, LB_N;

  sram_arbiter #(.WAIT_STATES(WS)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_dout_en(sram_dout_en), .sram_din(sram_din),
    .CE_N(CE_N), .OE_N(OE_N), .WR_N(WR_N), .UB_N(UB_N), .LB_N(LB_N)
  );

  // Second instance, 3 wait states, port B unused
  logic        a_req3, a_ack3, b_ack3, busy3;
  logic [15:0] a_addr3, a_rdata3, b_rdata3, sram_addr3, sram_dout3, sram_din3;
  logic        dout_en3, ce_n3, oe_n3, wr_n3, ub_n3, lb_n3;

  sram_arbiter #(.WAIT_STATES(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .a_req(a_req3), .a_we(1'b0), .a_addr(a_addr3), .a_wdata(16'h0000), .a_be(2'b11),
    .a_ack(a_ack3), .a_rdata(a_rdata3),
    .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0000), .b_wdata(16'h0000), .b_be(2'b00),
    .b_ack(b_ack3), .b_rdata(b_rdata3),
    .busy(busy3), .sram_addr(sram_addr3), .sram_dout(sram_dout3),
    .sram_dout_en(dout_en3), .sram_din(sram_din3),
    .CE_N(ce_n3), .OE_N(oe_n3), .WR_N(wr_n3), .UB_N(ub_n3), .LB_N(lb_n3)
  );

  // Simple memory for the slow instance: returns the inverted address
  assign sram_din3 = (!ce_n3 && !oe_n3) ? ~sram_addr3 : 16'h0000;

  // SRAM model for the main instance
  logic [15:0] mem [0:65535];
  assign sram_din = (!CE_N && !OE_N) ? mem[sram_addr] : 16'h0000;

  // Writes land while CE_N, WR_N are low and the data pins are driven
  always @(negedge CLK) begin
    if (!CE_N && !WR_N && sram_dout_en) begin
      if (!UB_N) mem[sram_addr][15:8] <= sram_dout[15:8];
      if (!LB_N) mem[sram_addr][7:0]  <= sram_dout[7:0];
    end
  end

  typedef struct packed {
    logic        port_b;
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_mem [logic [15:0]];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the ack just seen
  task automatic sb_pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("ack_port", {30'd0, a_ack, b_ack}, e.port_b ? 32'd1 : 32'd2);
      if (e.is_read) begin
        check_eq("rdata", e.port_b ? {16'd0, b_rdata} : {16'd0, a_rdata}, {16'd0, e.data});
      end
    end
  endtask

  // One transaction on one port, with pin-timing checks along the way
  task automatic run_txn(input bit pb, input bit we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be);
    exp_t        e;
    logic [15:0] merged;
    logic [15:0] other_rd;
    int ce_first, ce_last, wr_cnt, oe_cnt, ack_cyc;
    other_rd = pb ? a_rdata : b_rdata;
    @(posedge CLK); #1;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    end
    e.port_b  = pb;
    e.is_read = !we;
    merged = exp_mem.exists(addr) ? exp_mem[addr] : 16'h0000;
    if (we) begin
      if (be[1]) merged[15:8] = wd[15:8];
      if (be[0]) merged[7:0]  = wd[7:0];
      exp_mem[addr] = merged;
    end
    e.data = merged;
    sb_q.push_back(e);
    ce_first = -1; ce_last = -1; wr_cnt = 0; oe_cnt = 0; ack_cyc = -1;
    for (int c = 0; c < 16 && ack_cyc < 0; c++) begin
      @(negedge CLK);
      if (!CE_N) begin
        if (ce_first < 0) ce_first = c;
        ce_last = c;
      end
      if (!WR_N) wr_cnt++;
      if (!OE_N) oe_cnt++;
      if (c == 0) check_eq("busy_c0", {31'd0, busy}, 32'd0);
      if (c == 1) begin
        check_eq("setup_addr", {16'd0, sram_addr}, {16'd0, addr});
        check_eq("setup_ub_lb", {30'd0, UB_N, LB_N}, {30'd0, ~be[1], ~be[0]});
        check_eq("setup_den", {31'd0, sram_dout_en}, {31'd0, we});
        check_eq("setup_busy", {31'd0, busy}, 32'd1);
        if (we) check_eq("setup_dout", {16'd0, sram_dout}, {16'd0, wd});
      end
      if (a_ack || b_ack) begin
        ack_cyc = c;
        sb_pop_check();
        check_eq("done_den", {31'd0, sram_dout_en}, {31'd0, we});
        check_eq("done_addr", {16'd0, sram_addr}, {16'd0, addr});
        check_eq("done_strobes", {27'd0, CE_N, OE_N, WR_N, UB_N, LB_N}, 32'h1F);
        check_eq("other_rdata", pb ? {16'd0, a_rdata} : {16'd0, b_rdata}, {16'd0, other_rd});
      end
    end
    check_eq("ack_cycle", ack_cyc, 2 + WS);
    check_eq("ce_first", ce_first, 1);
    check_eq("ce_last", ce_last, 1 + WS);
    check_eq("wr_len", wr_cnt, we ? WS : 0);
    check_eq("oe_len", oe_cnt, we ? 0 : 1 + WS);
    @(posedge CLK); #1;
    a_req = 1'b0;
    b_req = 1'b0;
    sb_q.delete();
    if (we) check_eq("mem_word", {16'd0, mem[addr]}, {16'd0, merged});
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n_ack, last_ack, oe3, ack3;
    RST_N = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0000; a_wdata = 16'h0000; a_be = 2'b00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_wdata = 16'h0000; b_be = 2'b00;
    a_req3 = 1'b0; a_addr3 = 16'h0000;

    // Reset values
    repeat (2) @(negedge CLK);
    check_eq("rst_strobes", {27'd0, CE_N, OE_N, WR_N, UB_N, LB_N}, 32'h1F);
    check_eq("rst_den", {31'd0, sram_dout_en}, 32'd0);
    check_eq("rst_addr_dout", {sram_addr, sram_dout}, 32'd0);
    check_eq("rst_acks_busy", {29'd0, a_ack, b_ack, busy}, 32'd0);
    check_eq("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    RST_N = 1'b1;

    // Port A full write, port B read-back, port A read
    run_txn(1'b0, 1'b1, 16'h1234, 16'hBEEF, 2'b11);
    run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11);
    run_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 2'b11);

    // Byte-lane writes: lower byte only, then no lanes at all
    run_txn(1'b0, 1'b1, 16'h0040, 16'hFFFF, 2'b11);
    run_txn(1'b1, 1'b1, 16'h0040, 16'h55AA, 2'b01);
    check_eq("byte_write", {16'd0, mem[16'h0040]}, 32'h0000FFAA);
    run_txn(1'b0, 1'b1, 16'h0040, 16'h1234, 2'b00);
    check_eq("be00_unchanged", {16'd0, mem[16'h0040]}, 32'h0000FFAA);

    // Arbitration with both requests held across four transactions
    run_txn(1'b0, 1'b1, 16'h0100, 16'hAAAA, 2'b11);
    run_txn(1'b1, 1'b1, 16'h0200, 16'hBBBB, 2'b11);
    @(posedge CLK); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100; a_be = 2'b11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200; b_be = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.port_b  = RR ? (k % 2 == 1) : 1'b0;
      e.is_read = 1'b1;
      e.data    = e.port_b ? 16'hBBBB : 16'hAAAA;
      sb_q.push_back(e);
    end
    n_ack = 0;
    last_ack = -1;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge CLK);
      if (a_ack || b_ack) begin
        sb_pop_check();
        if (last_ack >= 0) check_eq("b2b_period", c - last_ack, 3 + WS);
        last_ack = c;
        n_ack++;
      end
    end
    check_eq("arb_acks", n_ack, 4);
    @(posedge CLK); #1;
    a_req = 1'b0;
    b_req = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge CLK);
    check_eq("arb_idle", {31'd0, busy}, 32'd0);

    // Reset during ACCESS of a write
    @(posedge CLK); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0500; a_wdata = 16'h7777; a_be = 2'b11;
    repeat (3) @(negedge CLK);
    check_eq("pre_rst_wr", {31'd0, WR_N}, 32'd0);
    #2 RST_N = 1'b0;
    #1;
    check_eq("async_rst_pins", {29'd0, WR_N, CE_N, sram_dout_en}, 32'h6);
    check_eq("async_rst_ack_busy", {30'd0, a_ack, busy}, 32'd0);
    check_eq("async_rst_rdata", {16'd0, a_rdata}, 32'd0);
    a_req = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (a_ack || b_ack) n_ack++;
      if (c == 2) RST_N = 1'b1;
    end
    check_eq("rst_no_ack", n_ack, 0);
    run_txn(1'b0, 1'b1, 16'h0300, 16'h1357, 2'b11);
    run_txn(1'b0, 1'b0, 16'h0300, 16'h0000, 2'b11);

    // Three wait states: OE_N low for 4 cycles, ack in cycle 5
    @(posedge CLK); #1;
    a_req3 = 1'b1;
    a_addr3 = 16'h0F0F;
    oe3 = 0;
    ack3 = -1;
    for (int c = 0; c < 20 && ack3 < 0; c++) begin
      @(negedge CLK);
      if (!oe_n3) oe3++;
      if (a_ack3) begin
        ack3 = c;
        check_eq("ws3_rdata", {16'd0, a_rdata3}, 32'h0000F0F0);
      end
    end
    @(posedge CLK); #1;
    a_req3 = 1'b0;
    check_eq("ws3_oe_len", oe3, 4);
    check_eq("ws3_ack_cycle", ack3, 5);

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and timing sequencer for the single external 16-bit asynchronous SRAM. It shares the SRAM between the CPU memory port (port A, behind `ram`) and the GPU buffer port (port B, behind `gpu`). It serialises their requests into properly strobed SRAM cycles, and every pin-level signal comes directly from a flop. It sits between those two clients and the `CE/OE/WR/UB/LB/A*/D*` pins of `top`.

## Interface
- `WAIT_STATES`, default 1: number of ACCESS cycles per transfer; legal range 1..15.
- `CLK  in  1`: system clock; all logic runs on its rising edge.
- `RST_N  in  1`: asynchronous, active-low reset.
- `a_req  in  1`: port A request; held high with stable `a_we/a_addr/a_wdata/a_be` until `a_ack`.
- `a_we  in  1`: 1 selects a write, 0 selects a read.
- `a_addr  in  16`: word address.
- `a_wdata  in  16`: write data.
- `a_be  in  2`: byte enables; bit 1 is the upper byte, bit 0 is the lower byte.
- `a_ack  out  1`: one-cycle completion pulse.
- `a_rdata  out  16`: read data; valid from the `a_ack` cycle and held until the next port A read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_be`, `b_ack`, `b_rdata`: port B, identical in direction, width and meaning to port A.
- `busy  out  1`: high whenever the FSM is not in IDLE.
- `sram_addr  out  16`: SRAM address pins.
- `sram_dout  out  16`: write data to the pins.
- `sram_dout_en  out  1`: tristate drive enable for the data pins.
- `sram_din  in  16`: data from the pins.
- `CE_N`, `OE_N`, `WR_N`, `UB_N`, `LB_N`  `out  1` each: active-low SRAM strobes.

## Operation
- FSM states: IDLE → SETUP → ACCESS → DONE → IDLE.
- IDLE:
  - Samples `a_req` and `b_req`.
  - If either is high, registers the winner's `we/addr/wdata/be` and moves to SETUP.
  - If neither is high, stays in IDLE.
- SETUP (1 cycle):
  - `CE_N=0` and `sram_addr` is driven.
  - `UB_N = ~be[1]`, `LB_N = ~be[0]`.
  - Read: `OE_N=0`.
  - Write: `sram_dout_en=1` with `sram_dout` driven; `WR_N` stays 1.
- ACCESS (`WAIT_STATES` cycles, counted by a 4-bit down-counter):
  - Read: `OE_N=0`.
  - Write: `WR_N=0`.
  - On the final ACCESS edge, a read captures `sram_din` into the winning port's rdata register.
- DONE (1 cycle):
  - All strobes return to 1.
  - `sram_addr` holds its value; for a write, `sram_dout` and `sram_dout_en=1` also hold (data hold time).
  - The winning port's ack is 1.
- Requests are not sampled during SETUP, ACCESS or DONE.
- Fixed priority (default): when both ports request in IDLE, A wins.
- `be=2'b00`:
  - The full cycle still runs, with `UB_N=LB_N=1`, and ack is produced.
  - For a write, memory is unchanged.
- Reads always capture all 16 bits regardless of `be`.
- Handshake:
  - A requester must drop req, or present a new request, in the cycle after its ack.
  - If req is still high in IDLE, it is taken as a new transaction.
- Reset values:
  - All strobes 1, `sram_dout_en=0`, `sram_addr=0`, `sram_dout=0`.
  - Acks 0, both rdata 0, `busy=0`, state IDLE.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously); the transaction is dropped with no ack.

## Timing
- Request high in cycle 0 with the FSM in IDLE gives:
  - SETUP in cycle 1;
  - ACCESS in cycles 2..1+`WAIT_STATES`;
  - ack in cycle 2+`WAIT_STATES` (cycle 3 at default).
- Back-to-back throughput is one access per 3+`WAIT_STATES` cycles.
- `sram_din` is sampled at the end of the last ACCESS cycle; with the default, `OE_N` has been low for 2 cycles by then.
- For writes, `WR_N` is low for exactly `WAIT_STATES` cycles, and address and data are stable one cycle before and one cycle after it.
- `busy` is high from SETUP through DONE inclusive.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register records the last winner.
  - On a simultaneous request, the port that did not win last time wins.
  - `last_grant` resets to B, so A wins the first contest.
  - A lone requester always wins and still updates `last_grant`.
- `SRAM_ARB_RR_EN` undefined: fixed priority, A over B; `last_grant` is not built.

## Test plan
- Port A write, `addr=16'h1234`, `wdata=16'hBEEF`, `be=11`, default wait states:
  - `CE_N` low in cycles 1–2, `WR_N` low only in cycle 2;
  - `a_ack` in cycle 3;
  - SRAM model holds `BEEF` at `1234`.
- Port B read of `16'h1234` with the model returning `BEEF`: `b_ack` in cycle 3, `b_rdata=16'hBEEF`, `a_rdata` unchanged.
- `a_req` and `b_req` held high continuously, 4 transactions:
  - without the macro, A is granted every time;
  - with `SRAM_ARB_RR_EN`, grants go A, B, A, B.
- Byte write `be=01`, `wdata=16'h55AA` over existing `16'hFFFF`: `UB_N=1`, `LB_N=0`, memory becomes `16'hFFAA`.
- `WAIT_STATES=3` read: `OE_N` low for 4 cycles, ack in cycle 5.
- `RST_N` pulled low during ACCESS of a write: `WR_N`, `CE_N` and `sram_dout_en` go inactive without waiting for a clock edge; no ack; after release the next request completes normally.
